// File: rtl/emergency_pkg.sv
// Shared types and constants for the emergency subsystem: alarm FSM states,
// source priority indices and default timing.
package emergency_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALARM    = 2'd1,
    SILENCED = 2'd2
  } alarm_state_t;

  localparam int SRC_SMOKE     = 0;
  localparam int SRC_PANIC     = 1;
  localparam int SRC_GAS       = 2;
  localparam int SRC_INTRUSION = 3;

  localparam int N_SRC_DEF         = 4;
  localparam int TICK_DIV_DEF      = 5_000_000;
  localparam int SILENCE_TICKS_DEF = 300;

endpackage

// File: rtl/alarm_arbiter_if.sv
// Request/button inputs and buzzer/LED outputs of the alarm arbiter.
interface alarm_arbiter_if #(
  parameter int N_SRC = 4
) ();
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] src_req;
  logic             btn_silence;
  logic             btn_clear;
  logic             buzzer;
  logic             led_alert;
  logic             alarm_active;
  logic [SRC_W-1:0] active_src;

  modport master (
    output src_req, btn_silence, btn_clear,
    input  buzzer, led_alert, alarm_active, active_src
  );

  modport slave (
    input  src_req, btn_silence, btn_clear,
    output buzzer, led_alert, alarm_active, active_src
  );
endinterface

// File: rtl/alarm_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle in which the count
// wraps from TICK_DIV-1 back to 0.
module alarm_tick_gen
  import emergency_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/alarm_arbiter.sv
// Arbitrates the shared active-low buzzer and alert LED between latched alarm
// sources, with per-source cadence, timed silence and clear.
module alarm_arbiter
  import emergency_pkg::*;
#(
  parameter int N_SRC         = N_SRC_DEF,
  parameter int TICK_DIV      = TICK_DIV_DEF,
  parameter int SILENCE_TICKS = SILENCE_TICKS_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alarm_arbiter_if.slave bus
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int SIL_W = $clog2(SILENCE_TICKS + 1);

  logic                 tick;
  logic [N_SRC-1:0]     src_prev_q, pending_q, pending_d, rise_src;
  logic                 sil_prev_q, clr_prev_q, sil_rise, clr_rise, preempt;
  alarm_state_t         state_q, state_d;
  logic [SRC_W-1:0]     owner_q, owner_d;
  logic [2:0]           phase_q, phase_d;
  logic [SIL_W-1:0]     sil_cnt_q, sil_cnt_d;
  logic                 buzzer_q, buzzer_d, led_q, led_d, active_q, active_d;
  logic [SRC_W-1:0]     active_src_q, active_src_d;
  logic                 buz_on;
  int                   owner_i;

  alarm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Clear masks first so a same-cycle new edge is never lost.
  always_comb begin
    rise_src  = bus.src_req & ~src_prev_q;
    sil_rise  = bus.btn_silence & ~sil_prev_q;
    clr_rise  = bus.btn_clear & ~clr_prev_q;
    pending_d = (clr_rise ? (pending_q & bus.src_req) : pending_q) | rise_src;
    owner_d   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_d[i]) owner_d = SRC_W'(i);
    end
    preempt = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rise_src[i] && (SRC_W'(i) < owner_q)) preempt = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sil_cnt_d = sil_cnt_q;
    if (pending_d == '0) begin
      state_d   = IDLE;
      sil_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = ALARM;
        ALARM: begin
          if (sil_rise) begin
            state_d   = SILENCED;
            sil_cnt_d = SIL_W'(SILENCE_TICKS);
          end
        end
        SILENCED: begin
          if (preempt) begin
            state_d = ALARM;
          end else if (tick) begin
            if (sil_cnt_q <= SIL_W'(1)) begin
              state_d   = ALARM;
              sil_cnt_d = '0;
            end else begin
              sil_cnt_d = sil_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    phase_d = phase_q;
    if (state_d == IDLE) phase_d = '0;
    else if ((owner_d != owner_q) || (state_d == ALARM && state_q != ALARM)) phase_d = '0;
    else if (tick) phase_d = phase_q + 3'd1;
  end

  // Outputs are decoded from the registered state, so they trail it by a cycle.
  always_comb begin
    owner_i = int'(owner_q);
    buz_on  = 1'b0;
    if (state_q == ALARM) begin
      if (owner_i == 0)      buz_on = 1'b1;
      else if (owner_i == 1) buz_on = ~phase_q[0];
      else if (owner_i == 2) buz_on = (phase_q < 3'd4);
      else                   buz_on = (phase_q == 3'd0);
    end
    buzzer_d     = ~buz_on;
    led_d        = ~((state_q != IDLE) && !phase_q[1]);
    active_d     = (state_q != IDLE);
    active_src_d = owner_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev_q   <= '0;
      sil_prev_q   <= 1'b0;
      clr_prev_q   <= 1'b0;
      pending_q    <= '0;
      state_q      <= IDLE;
      owner_q      <= '0;
      phase_q      <= '0;
      sil_cnt_q    <= '0;
      buzzer_q     <= 1'b1;
      led_q        <= 1'b1;
      active_q     <= 1'b0;
      active_src_q <= '0;
    end else begin
      src_prev_q   <= bus.src_req;
      sil_prev_q   <= bus.btn_silence;
      clr_prev_q   <= bus.btn_clear;
      pending_q    <= pending_d;
      state_q      <= state_d;
      owner_q      <= owner_d;
      phase_q      <= phase_d;
      sil_cnt_q    <= sil_cnt_d;
      buzzer_q     <= buzzer_d;
      led_q        <= led_d;
      active_q     <= active_d;
      active_src_q <= active_src_d;
    end
  end

  assign bus.buzzer       = buzzer_q;
  assign bus.led_alert    = led_q;
  assign bus.alarm_active = active_q;
  assign bus.active_src   = active_src_q;
endmodule

// File: tb/tb_alarm_arbiter.sv
// Directed vector bench for alarm_arbiter with TICK_DIV = 4, SILENCE_TICKS = 5.
module tb_alarm_arbiter;

  typedef struct {
    bit         do_rst;
    int         cyc;
    logic [3:0] src;
    logic       sil;
    logic       clr;
    logic       buz;
    logic       led;
    logic       act;
    logic [1:0] asrc;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  alarm_arbiter_if #(.N_SRC(4)) bus ();

  alarm_arbiter #(
    .N_SRC         (4),
    .TICK_DIV      (4),
    .SILENCE_TICKS (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input bit r, input int c, input logic [3:0] s, input logic si,
                     input logic cl, input logic b, input logic l, input logic a,
                     input logic [1:0] as);
    vec_t v;
    v.do_rst = r; v.cyc = c; v.src = s; v.sil = si; v.clr = cl;
    v.buz = b; v.led = l; v.act = a; v.asrc = as;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic b, input logic l,
                       input logic a, input logic [1:0] as);
    checks++;
    if ({bus.buzzer, bus.led_alert, bus.alarm_active, bus.active_src} !== {b, l, a, as}) begin
      errors++;
      $display("FAIL %s #%0d t=%0t: got buz=%b led=%b act=%b src=%0d, want buz=%b led=%b act=%b src=%0d",
               nm, idx, $time, bus.buzzer, bus.led_alert, bus.alarm_active, bus.active_src,
               b, l, a, as);
    end
  endtask

  // Asserts reset (seen asynchronously), holds it 3 clocks, releases #1 after an edge.
  task automatic do_reset(input logic [3:0] s);
    bus.src_req = s; bus.btn_silence = 1'b0; bus.btn_clear = 1'b0;
    reset = 1'b1;
    #1 check("reset_async", 0, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", i, 1'b1, 1'b1, 1'b0, 2'd0);
    end
    reset = 1'b0;
  endtask

  task automatic step_check(input string nm, input int idx, input logic b, input logic l,
                            input logic a, input logic [1:0] as);
    @(posedge clk); #1;
    check(nm, idx, b, l, a, as);
  endtask

  initial begin
    // Pulsed gas source: 4-phase-on/4-phase-off cadence, then clear to IDLE.
    add(1, 1, 4'b0100, 0, 0, 1, 1, 0, 0);
    add(0, 7, 4'b0000, 0, 0, 0, 0, 1, 2);
    add(0, 8, 4'b0000, 0, 0, 0, 1, 1, 2);
    add(0, 8, 4'b0000, 0, 0, 1, 0, 1, 2);
    add(0, 8, 4'b0000, 0, 0, 1, 1, 1, 2);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0000, 0, 1, 0, 0, 1, 2);
    add(0, 3, 4'b0000, 0, 0, 1, 1, 0, 0);
    // Intrusion running, smoke preempts and restarts the phase.
    add(1, 1, 4'b1000, 0, 0, 1, 1, 0, 0);
    add(0, 3, 4'b1000, 0, 0, 0, 0, 1, 3);
    add(0, 2, 4'b1000, 0, 0, 1, 0, 1, 3);
    add(0, 1, 4'b1001, 0, 0, 1, 0, 1, 3);
    add(0, 5, 4'b1001, 0, 0, 0, 0, 1, 0);
    add(0, 4, 4'b1001, 0, 0, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0, 1, 1, 0);
    add(0, 2, 4'b0000, 0, 0, 1, 1, 0, 0);
    // Panic silenced for 5 ticks, re-arms; silenced again, smoke re-arms at once.
    add(1, 1, 4'b0010, 0, 0, 1, 1, 0, 0);
    add(0, 3, 4'b0010, 0, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0010, 1, 0, 1, 0, 1, 1);
    add(0, 3, 4'b0010, 0, 0, 1, 0, 1, 1);
    add(0, 8, 4'b0010, 0, 0, 1, 1, 1, 1);
    add(0, 8, 4'b0010, 0, 0, 1, 0, 1, 1);
    add(0, 4, 4'b0010, 0, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0010, 0, 0, 1, 0, 1, 1);
    add(0, 1, 4'b0010, 1, 0, 1, 0, 1, 1);
    add(0, 1, 4'b0010, 0, 0, 1, 0, 1, 1);
    add(0, 1, 4'b0011, 0, 0, 1, 0, 1, 1);
    add(0, 3, 4'b0011, 0, 0, 0, 0, 1, 0);
    // Clear keeps held sources, new edge beats clear, clear beats silence.
    add(1, 1, 4'b0110, 0, 0, 1, 1, 0, 0);
    add(0, 1, 4'b0010, 0, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0010, 0, 1, 0, 0, 1, 1);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 1, 1);
    add(0, 1, 4'b0000, 0, 1, 1, 0, 1, 1);
    add(0, 2, 4'b0000, 0, 0, 1, 1, 0, 0);
    add(0, 1, 4'b0100, 0, 1, 1, 1, 0, 0);
    add(0, 1, 4'b0100, 0, 0, 0, 0, 1, 2);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 1, 2);
    add(0, 2, 4'b0000, 0, 0, 1, 1, 0, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset(4'b0000);
      bus.src_req     = vecs[i].src;
      bus.btn_silence = vecs[i].sil;
      bus.btn_clear   = vecs[i].clr;
      for (int c = 0; c < vecs[i].cyc; c++)
        step_check("vec", i, vecs[i].buz, vecs[i].led, vecs[i].act, vecs[i].asrc);
    end

    // Reset mid-alarm with smoke held: outputs drop at once, re-assert 2 cycles after release.
    do_reset(4'b0000);
    bus.src_req = 4'b0001;
    step_check("midrst_pre", 1, 1'b1, 1'b1, 1'b0, 2'd0);
    for (int c = 2; c <= 4; c++) step_check("midrst_pre", c, 1'b0, 1'b0, 1'b1, 2'd0);
    do_reset(4'b0001);
    step_check("midrst_post", 1, 1'b1, 1'b1, 1'b0, 2'd0);
    step_check("midrst_post", 2, 1'b0, 1'b0, 1'b1, 2'd0);
    step_check("midrst_post", 3, 1'b0, 1'b0, 1'b1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_arbiter.md
# alarm_arbiter

Shares a single active-low buzzer and alert LED among several alarm sources (smoke, panic button, gas, intrusion) in the emergency subsystem. Latches rising edges per source, grants the outputs to the highest-priority pending source, and drives a source-specific on/off cadence. Supports timed silencing and clearing of alarms. Sits between the debounced sensor/button inputs and the board buzzer/LED pins.

## Interface
- N_SRC, 4: number of alarm sources; index 0 is highest priority.
- TICK_DIV, 5_000_000: clk cycles per pattern tick (100 ms at 50 MHz).
- SILENCE_TICKS, 300: ticks a silence lasts before the buzzer re-arms (30 s).
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- src_req  in  N_SRC  level alarm requests, already synchronous to clk.
- btn_silence  in  1  silence request, synchronous level.
- btn_clear  in  1  clear request, synchronous level.
- buzzer  out  1  active low.
- led_alert  out  1  active low.
- alarm_active  out  1  high while state is not IDLE.
- active_src  out  $clog2(N_SRC)  index of the current owner; 0 in IDLE.

## Operation
- Edge detection:
  - Per-bit prev registers for src_req, btn_silence and btn_clear; each prev register resets to 0.
  - A source already high at reset release counts as a rising edge.
  - A rising src_req edge sets pending[i].
- FSM states: IDLE, ALARM, SILENCED.
  - IDLE -> ALARM when pending != 0.
  - ALARM -> SILENCED on a btn_silence rising edge; the silence counter loads SILENCE_TICKS.
  - SILENCED -> ALARM when the silence counter reaches 0 on a tick.
  - SILENCED -> ALARM immediately when a new edge arrives on a source with a lower index than owner.
  - Any state -> IDLE when pending becomes 0.
- btn_clear rising edge:
  - pending <= pending & src_req, so sources still asserted stay pending.
  - The same-cycle new-edge set applies after the clear mask; a new edge wins.
- Simultaneous btn_clear and btn_silence edges: clear is evaluated first; silence applies only if pending remains nonzero.
- Owner: lowest set index of pending, re-evaluated every cycle.
  - An owner change or entry to ALARM resets phase to 0.
  - Silence is not cancelled by an owner change to a lower-priority source.
- Phase: 3-bit counter, increments on each tick while not IDLE, wraps 7 -> 0.
- Buzzer cadence in ALARM, by owner:
  - 0: continuous.
  - 1: on when phase[0] == 0.
  - 2: on when phase < 4.
  - 3 or higher: on when phase == 0.
- Buzzer is off in SILENCED and IDLE.
- LED is on when phase[1] == 0 in ALARM or SILENCED; off in IDLE.

## Timing
- Reset values:
  - buzzer = 1, led_alert = 1, alarm_active = 0, active_src = 0.
  - pending = 0, state = IDLE, phase = 0.
  - Prescaler and silence counter = 0.
- All outputs are registered.
- Latency: src_req first sampled high at edge k -> state ALARM after edge k -> buzzer, alarm_active and active_src valid after edge k+1.
- Silence/clear: a button edge sampled at edge k changes state at edge k; outputs follow at edge k+1.
- Tick:
  - Single-cycle pulse when the prescaler wraps from TICK_DIV-1 to 0.
  - The prescaler free-runs, so phase 0 may last less than one full tick after entry.
- The silence counter decrements only on ticks. Expiry at count 0 returns to ALARM on that same tick edge.
- Reset asserted mid-alarm forces the reset values asynchronously. After release, sources still high re-trigger via the prev = 0 rule.

## Structure
- Shared package emergency_pkg holds:
  - alarm_state_t enum (IDLE, ALARM, SILENCED).
  - Source index constants: SRC_SMOKE = 0, SRC_PANIC = 1, SRC_GAS = 2, SRC_INTRUSION = 3.
  - The default timing constants.
- One sub-module, alarm_tick_gen: prescaler that produces the tick pulse, parameterised by TICK_DIV.
- Owner selection, pattern decode and FSM live in alarm_arbiter.

## Test plan
All scenarios use TICK_DIV = 4 and SILENCE_TICKS = 5.
- Power-up: reset held 3 cycles, src_req = 0 -> buzzer = 1, led_alert = 1, alarm_active = 0 throughout.
- Pulse src_req[2] for 1 cycle:
  - alarm_active = 1 two cycles later, active_src = 2.
  - Buzzer low for phases 0..3 (16 cycles), then high for 16 cycles, repeating.
- Preemption: src_req[3] alarm running, then raise src_req[0] -> active_src = 0 and buzzer continuous low from the following cycle; phase restarts at 0.
- Silence: with src 1 active, pulse btn_silence:
  - buzzer = 1 and the LED keeps blinking.
  - After 5 ticks (about 20 cycles) the buzzer resumes the src 1 cadence.
  - A src_req[0] edge during silence re-arms immediately.
- Clear:
  - src_req[1] held high, src_req[2] low, both pending; pulse btn_clear -> pending = 0b0010, state stays ALARM.
  - Drop src_req[1], clear again -> IDLE, buzzer = 1.
- Reset mid-alarm with src_req[0] held high -> outputs inactive during reset; alarm re-asserts 2 cycles after release.
